// File: rtl/dmi_pkg.sv
// Shared DMI arbiter types: op and FSM encodings, payload struct, bus widths.
package dmi_pkg;

    localparam int unsigned DMI_ABITS = 7;
    localparam int unsigned DMI_DBITS = 32;

    typedef enum logic [1:0] {
        NOP      = 2'd0,
        READ     = 2'd1,
        WRITE    = 2'd2,
        RESERVED = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } dmi_arb_state_e;

    typedef struct packed {
        dmi_op_e                op;
        logic [DMI_ABITS-1:0]   address;
        logic [DMI_DBITS-1:0]   data;
    } dmi_req_t;

    // Only reads and writes reach the Debug Module; NOP/RESERVED complete locally.
    function automatic logic op_needs_dm(input dmi_op_e op);
        return (op == READ) || (op == WRITE);
    endfunction

endpackage

// File: rtl/dmi_arbiter_if.sv
// Bundle of requester-side and DM-side DMI signals around the arbiter.
// master: the arbiter itself; slave: the transports plus the Debug Module.
interface dmi_arbiter_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned ABITS = dmi_pkg::DMI_ABITS,
    parameter int unsigned DBITS = dmi_pkg::DMI_DBITS
) ();

    logic [NREQ-1:0]            req_start;
    logic [NREQ-1:0][1:0]       req_op;
    logic [NREQ-1:0][ABITS-1:0] req_address;
    logic [NREQ-1:0][DBITS-1:0] req_data_o;
    logic [NREQ-1:0]            req_finish;
    logic [DBITS-1:0]           req_data_i;
    logic [NREQ-1:0]            req_busy;

    logic                       dmi_start;
    logic [1:0]                 dmi_op;
    logic [ABITS-1:0]           dmi_address;
    logic [DBITS-1:0]           dmi_data_o;
    logic [DBITS-1:0]           dmi_data_i;
    logic                       dmi_finish;

    modport master (
        input  req_start, req_op, req_address, req_data_o,
        input  dmi_data_i, dmi_finish,
        output req_finish, req_data_i, req_busy,
        output dmi_start, dmi_op, dmi_address, dmi_data_o
    );

    modport slave (
        output req_start, req_op, req_address, req_data_o,
        output dmi_data_i, dmi_finish,
        input  req_finish, req_data_i, req_busy,
        input  dmi_start, dmi_op, dmi_address, dmi_data_o
    );

endinterface

// File: rtl/dmi_req_slot.sv
// One requester slot: pending flag plus payload latch. A new start is dropped
// while pending, except in the completion cycle, where the new request wins.
module dmi_req_slot
    import dmi_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_i,
    input  logic     clr_i,
    input  dmi_req_t payload_i,
    output logic     pending_o,
    output dmi_req_t payload_o
);

    logic     pending_q, pending_d;
    dmi_req_t payload_q, payload_d;

    // Next-state: accept when free or being freed this cycle; otherwise honour clear.
    always_comb begin
        pending_d = pending_q;
        payload_d = payload_q;
        if (set_i && (!pending_q || clr_i)) begin
            pending_d = 1'b1;
            payload_d = payload_i;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            payload_q <= '0;
        end else begin
            pending_q <= pending_d;
            payload_q <= payload_d;
        end
    end

    assign pending_o = pending_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one Debug Module DMI bus between NREQ transports.
// Optional watchdog in WAIT enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
    import dmi_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned ABITS          = DMI_ABITS,
    parameter int unsigned DBITS          = DMI_DBITS,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    dmi_arbiter_if.master bus,
    output logic          timeout
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    dmi_arb_state_e   state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_q, rr_d;
    logic             dmi_start_q, dmi_start_d;
    dmi_op_e          dmi_op_q, dmi_op_d;
    logic [ABITS-1:0] dmi_addr_q, dmi_addr_d;
    logic [DBITS-1:0] dmi_wdata_q, dmi_wdata_d;
    logic [NREQ-1:0]  req_finish_q, req_finish_d;
    logic [DBITS-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]  pending;
    logic [NREQ-1:0]  slot_clr_c;
    dmi_req_t         slot_in  [NREQ];
    dmi_req_t         slot_out [NREQ];
    dmi_req_t         sel_c;
    logic [GW-1:0]    pick_c;
    logic             found_c;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]    wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
`else
    logic [31:0]      unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // Per-requester pending flag and payload latch.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        assign slot_in[gi] = '{
            op:      dmi_op_e'(bus.req_op[gi]),
            address: DMI_ABITS'(bus.req_address[gi]),
            data:    DMI_DBITS'(bus.req_data_o[gi])
        };

        dmi_req_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .set_i     (bus.req_start[gi]),
            .clr_i     (slot_clr_c[gi]),
            .payload_i (slot_in[gi]),
            .pending_o (pending[gi]),
            .payload_o (slot_out[gi])
        );
    end

    // First pending requester at or after the round-robin pointer, with wrap.
    always_comb begin
        int unsigned   idx;
        logic [GW-1:0] idx_g;
        pick_c  = '0;
        found_c = 1'b0;
        idx     = 0;
        idx_g   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx   = (32'(rr_q) + k) % NREQ;
            idx_g = GW'(idx);
            if (!found_c && pending[idx_g]) begin
                found_c = 1'b1;
                pick_c  = idx_g;
            end
        end
    end

    assign sel_c = slot_out[pick_c];

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        dmi_start_d  = 1'b0;
        dmi_op_d     = dmi_op_q;
        dmi_addr_d   = dmi_addr_q;
        dmi_wdata_d  = dmi_wdata_q;
        req_finish_d = '0;
        rdata_d      = rdata_q;
        slot_clr_c   = '0;
`ifdef DMI_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_d     = pick_c;
                    dmi_op_d    = sel_c.op;
                    dmi_addr_d  = ABITS'(sel_c.address);
                    dmi_wdata_d = DBITS'(sel_c.data);
                    if (op_needs_dm(sel_c.op)) begin
                        state_d     = ISSUE;
                        dmi_start_d = 1'b1;
                    end else begin
                        state_d              = RESPOND;
                        req_finish_d[pick_c] = 1'b1;
                        rdata_d              = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (bus.dmi_finish) begin
                    state_d               = RESPOND;
                    req_finish_d[grant_q] = 1'b1;
                    rdata_d               = bus.dmi_data_i;
`ifdef DMI_ARB_TIMEOUT_EN
                end else if (wdog_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d               = RESPOND;
                    req_finish_d[grant_q] = 1'b1;
                    rdata_d               = '1;
                    timeout_d             = 1'b1;
                end else begin
                    wdog_d = wdog_q + CW'(1);
`endif
                end
            end
            RESPOND: begin
                slot_clr_c[grant_q] = 1'b1;
                rr_d    = (grant_q == GW'(NREQ - 1)) ? '0 : GW'(grant_q + GW'(1));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            dmi_start_q  <= 1'b0;
            dmi_op_q     <= NOP;
            dmi_addr_q   <= '0;
            dmi_wdata_q  <= '0;
            req_finish_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            dmi_start_q  <= dmi_start_d;
            dmi_op_q     <= dmi_op_d;
            dmi_addr_q   <= dmi_addr_d;
            dmi_wdata_q  <= dmi_wdata_d;
            req_finish_q <= req_finish_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign bus.req_finish  = req_finish_q;
    assign bus.req_data_i  = rdata_q;
    assign bus.req_busy    = pending;
    assign bus.dmi_start   = dmi_start_q;
    assign bus.dmi_op      = dmi_op_q;
    assign bus.dmi_address = dmi_addr_q;
    assign bus.dmi_data_o  = dmi_wdata_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Scoreboard bench for dmi_arbiter: stimulus queues expected DM accesses and
// completions; a monitor pops and compares whenever the DUT presents them.
module tb_dmi_arbiter;
    import dmi_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned ABITS = 7;
    localparam int unsigned DBITS = 32;
    localparam int unsigned TO_CYC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic timeout;

    dmi_arbiter_if #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS)) bus ();

    dmi_arbiter #(
        .NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [1:0] op; logic [6:0] addr; logic [31:0] wdata; } dm_exp_t;
    typedef struct { int cyc; int idx; logic [31:0] data; } fin_exp_t;

    dm_exp_t  dm_q[$];
    fin_exp_t fin_q[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          dm_delay = 2;
    logic [31:0] dm_rdata = '0;
    bit          dm_enable = 1'b1;
    int          kick_req = 0;
    int          kick_done = 0;
    int          c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_finish"},  64'(bus.req_finish),  64'(0));
        check({tag, "_req_data_i"},  64'(bus.req_data_i),  64'(0));
        check({tag, "_req_busy"},    64'(bus.req_busy),    64'(0));
        check({tag, "_dmi_start"},   64'(bus.dmi_start),   64'(0));
        check({tag, "_dmi_op"},      64'(bus.dmi_op),      64'(0));
        check({tag, "_dmi_address"}, 64'(bus.dmi_address), 64'(0));
        check({tag, "_dmi_data_o"},  64'(bus.dmi_data_o),  64'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        bus.req_start[i]   = 1'b1;
        bus.req_op[i]      = op;
        bus.req_address[i] = a;
        bus.req_data_o[i]  = d;
    endtask

    task automatic push_dm(input int cc, input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        dm_exp_t e;
        e.cyc = cc; e.op = op; e.addr = a; e.wdata = d;
        dm_q.push_back(e);
    endtask

    task automatic push_fin(input int cc, input int idx, input logic [31:0] d);
        fin_exp_t e;
        e.cyc = cc; e.idx = idx; e.data = d;
        fin_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((dm_q.size() != 0 || fin_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain_left"}, 64'(dm_q.size() + fin_q.size()), 64'(0));
        dm_q.delete();
        fin_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic dm_respond(input int d, input logic [31:0] data);
        repeat (d) @(posedge clk);
        #1;
        bus.dmi_finish = 1'b1;
        bus.dmi_data_i = data;
        @(posedge clk);
        #1;
        bus.dmi_finish = 1'b0;
    endtask

    // Debug Module model: answers each dmi_start after dm_delay cycles, or
    // emits a stray finish pulse on request.
    initial begin : dm_model
        bus.dmi_finish = 1'b0;
        bus.dmi_data_i = '0;
        forever begin
            @(negedge clk);
            if (dm_enable && bus.dmi_start === 1'b1) begin
                dm_respond(dm_delay, dm_rdata);
            end else if (kick_req != kick_done) begin
                kick_done++;
                dm_respond(1, 32'hBAD0_BAD0);
            end
        end
    end

    // Monitor: compares every DM access and every completion against the queues.
    initial begin : monitor
        dm_exp_t  de;
        fin_exp_t fe;
        forever begin
            @(negedge clk);
            if (bus.dmi_start !== 1'b0) begin
                if (dm_q.size() == 0) begin
                    check("unexpected_dmi_start", 64'(bus.dmi_start), 64'(0));
                end else begin
                    de = dm_q.pop_front();
                    check("dmi_request", 64'({bus.dmi_op, bus.dmi_address, bus.dmi_data_o}),
                          64'({de.op, de.addr, de.wdata}));
                    check("dmi_start_cycle", 64'(cyc), 64'(de.cyc));
                end
            end
            if (bus.req_finish !== '0) begin
                if (fin_q.size() == 0) begin
                    check("unexpected_req_finish", 64'(bus.req_finish), 64'(0));
                end else begin
                    fe = fin_q.pop_front();
                    check("finish_vector", 64'(bus.req_finish), 64'(1) << fe.idx);
                    check("finish_data", 64'(bus.req_data_i), 64'(fe.data));
                    check("finish_cycle", 64'(cyc), 64'(fe.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.req_start   = '0;
        bus.req_op      = '0;
        bus.req_address = '0;
        bus.req_data_o  = '0;
        rst_n = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        check("reset_timeout", 64'(timeout), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single read: dmi_start 2 cycles after start, finish 1 cycle after dmi_finish.
        dm_enable = 1'b1; dm_delay = 5; dm_rdata = 32'h0000_0ABC;
        c = cyc;
        req(0, 2'd1, 7'h11, 32'h0);
        push_dm(c + 2, 2'd1, 7'h11, 32'h0);
        push_fin(c + 8, 0, 32'h0000_0ABC);
        tick(); bus.req_start = '0;
        check("read_busy", 64'(bus.req_busy), 64'(2'b01));
        drain("read", 40);
        check("read_data_held", 64'(bus.req_data_i), 64'(32'h0000_0ABC));
        check("read_busy_clear", 64'(bus.req_busy), 64'(0));

        // Simultaneous writes from reset: requester 0 first, then 1.
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        dm_delay = 2; dm_rdata = 32'h0000_0055;
        c = cyc;
        req(0, 2'd2, 7'h10, 32'h1111_0000);
        req(1, 2'd2, 7'h04, 32'h2222_0001);
        push_dm(c + 2, 2'd2, 7'h10, 32'h1111_0000);
        push_dm(c + 7, 2'd2, 7'h04, 32'h2222_0001);
        push_fin(c + 5, 0, 32'h0000_0055);
        push_fin(c + 10, 1, 32'h0000_0055);
        tick(); bus.req_start = '0;
        check("pair_busy", 64'(bus.req_busy), 64'(2'b11));
        drain("pair", 60);

        // Single read on requester 0 moves the pointer to requester 1.
        dm_rdata = 32'h0000_0077;
        c = cyc;
        req(0, 2'd1, 7'h05, 32'h0);
        push_dm(c + 2, 2'd1, 7'h05, 32'h0);
        push_fin(c + 5, 0, 32'h0000_0077);
        tick(); bus.req_start = '0;
        drain("rr_move", 40);

        // Repeat pair: requester 1 now wins.
        c = cyc;
        req(0, 2'd2, 7'h12, 32'h0000_000A);
        req(1, 2'd2, 7'h13, 32'h0000_000B);
        push_dm(c + 2, 2'd2, 7'h13, 32'h0000_000B);
        push_dm(c + 7, 2'd2, 7'h12, 32'h0000_000A);
        push_fin(c + 5, 1, 32'h0000_0077);
        push_fin(c + 10, 0, 32'h0000_0077);
        tick(); bus.req_start = '0;
        drain("pair_rr", 60);

        // Duplicate start while pending is dropped; latch keeps address 0x10.
        dm_delay = 3; dm_rdata = 32'h1234_5678;
        c = cyc;
        req(0, 2'd1, 7'h10, 32'h0);
        push_dm(c + 2, 2'd1, 7'h10, 32'h0);
        push_fin(c + 6, 0, 32'h1234_5678);
        tick();
        req(0, 2'd1, 7'h20, 32'h0);
        tick(); bus.req_start = '0;
        drain("dup", 40);
        check("dup_busy_clear", 64'(bus.req_busy), 64'(0));

        // NOP completes locally with zero data; DMI registers still take its payload.
        c = cyc;
        req(1, 2'd0, 7'h33, 32'h0000_DEAD);
        push_fin(c + 2, 1, 32'h0);
        tick(); bus.req_start = '0;
        drain("nop", 20);
        check("nop_dmi_address", 64'(bus.dmi_address), 64'(7'h33));
        check("nop_dmi_op", 64'(bus.dmi_op), 64'(0));
        check("nop_dmi_data_o", 64'(bus.dmi_data_o), 64'(32'h0000_DEAD));

        // Reserved op, then a new start in its completion cycle wins.
        c = cyc;
        req(0, 2'd3, 7'h44, 32'h1);
        push_fin(c + 2, 0, 32'h0);
        tick(); bus.req_start = '0;
        tick();
        req(0, 2'd0, 7'h45, 32'h0);
        push_fin(c + 4, 0, 32'h0);
        tick(); bus.req_start = '0;
        drain("reserved_setwins", 20);
        check("setwins_busy_clear", 64'(bus.req_busy), 64'(0));

        // Reset during WAIT aborts silently; a late dmi_finish is ignored.
        dm_enable = 1'b0;
        c = cyc;
        req(0, 2'd1, 7'h15, 32'h0);
        push_dm(c + 2, 2'd1, 7'h15, 32'h0);
        tick(); bus.req_start = '0;
        tick(); tick();
        check("wait_issued", 64'(dm_q.size()), 64'(0));
        check("wait_busy", 64'(bus.req_busy), 64'(2'b01));
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("abort");
        tick();
        rst_n = 1'b1;
        kick_req++;
        repeat (6) tick();
        check_zero("late_finish");
        dm_enable = 1'b1;
        c = cyc;
        req(1, 2'd0, 7'h01, 32'h0);
        push_fin(c + 2, 1, 32'h0);
        tick(); bus.req_start = '0;
        drain("after_abort", 20);

`ifdef DMI_ARB_TIMEOUT_EN
        // Watchdog: 8 WAIT cycles without dmi_finish yields all-ones and sticky flag.
        dm_enable = 1'b0;
        c = cyc;
        req(0, 2'd1, 7'h16, 32'h0);
        push_dm(c + 2, 2'd1, 7'h16, 32'h0);
        push_fin(c + 11, 0, 32'hFFFF_FFFF);
        tick(); bus.req_start = '0;
        drain("timeout", 40);
        check("timeout_set", 64'(timeout), 64'(1));
        dm_enable = 1'b1; dm_delay = 1; dm_rdata = 32'h0000_0099;
        c = cyc;
        req(0, 2'd1, 7'h17, 32'h0);
        push_dm(c + 2, 2'd1, 7'h17, 32'h0);
        push_fin(c + 4, 0, 32'h0000_0099);
        tick(); bus.req_start = '0;
        drain("post_timeout", 40);
        check("timeout_sticky", 64'(timeout), 64'(1));
`else
        check("timeout_tied", 64'(timeout), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
